// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide controller: op codes, FSM states,
// divide iteration count and small two's-complement helpers.
package muldiv_ctrl_pkg;

    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic [31:0] cond_neg32(input logic [31:0] value, input logic negate);
        return negate ? (32'd0 - value) : value;
    endfunction

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] value, input logic is_signed);
        return cond_neg32(value, is_signed & value[31]);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, shift in the quotient bit.
module div_step
    import muldiv_ctrl_pkg::*;
(
    input  logic [31:0] rem_i,
    input  logic [31:0] quot_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quot_o
);

    logic [31:0] shifted_s;
    logic [31:0] diff_s;
    logic        fits_s;

    // rem_i[31] is the 33rd bit of the shifted remainder; when set it always exceeds the divisor.
    assign shifted_s = {rem_i[30:0], quot_i[31]};
    assign fits_s    = rem_i[31] | (shifted_s >= divisor_i);
    assign diff_s    = shifted_s - divisor_i;

    assign rem_o  = fits_s ? diff_s : shifted_s;
    assign quot_o = {quot_i[30:0], fits_s};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller feeding HI/LO, with pipeline stall request.
// Optional build macro: MULDIV_DIV0_EARLY_OUT_EN (zero divisor completes without iterating).
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  is_div_i,
    input  logic [1:0]  is_mul_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        stall_req_o,
    output logic        result_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        signed_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        valid_q;

    logic        div_req_s;
    logic        mul_req_s;
    logic        op_req_s;
    logic        div_signed_s;
    logic        start_signed_s;
    logic [31:0] divisor_mag_s;
    logic [31:0] rem_d;
    logic [31:0] quot_d;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] product_s;

    assign div_req_s      = (is_div_i == OP_DIV) || (is_div_i == OP_DIVU);
    assign mul_req_s      = (is_mul_i == OP_MULT) || (is_mul_i == OP_MULTU);
    assign op_req_s       = div_req_s | mul_req_s;
    assign div_signed_s   = (is_div_i == OP_DIV);
    assign start_signed_s = div_req_s ? div_signed_s : (is_mul_i == OP_MULT);

    assign stall_req_o    = op_req_s & ~flush_i & (state_q != ST_DONE);
    assign result_valid_o = valid_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign busy_o         = (state_q != ST_IDLE);

    assign divisor_mag_s = mag32(op_b_q, signed_q);

    div_step u_div_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_mag_s),
        .rem_o     (rem_d),
        .quot_o    (quot_d)
    );

    // Quotient sign follows the operand sign mismatch; remainder follows the dividend.
    assign quot_fix_s = cond_neg32(quot_d, signed_q & (op_a_q[31] ^ op_b_q[31]));
    assign rem_fix_s  = cond_neg32(rem_d, signed_q & op_a_q[31]);

    // 33-bit sign/zero extension carried on to 64 bits; the low 64 product bits are exact.
    assign mul_a_s   = {{32{signed_q & op_a_q[31]}}, op_a_q};
    assign mul_b_s   = {{32{signed_q & op_b_q[31]}}, op_b_q};
    assign product_s = mul_a_s * mul_b_s;

`ifdef MULDIV_DIV0_EARLY_OUT_EN
    logic [31:0] div0_lo_s;
    logic        div0_s;

    assign div0_s    = (src_b_i == 32'd0);
    assign div0_lo_s = (div_signed_s & src_a_i[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif

    // Controller FSM: operand latch, iteration, result registers and valid flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            signed_q <= 1'b0;
            rem_q    <= 32'd0;
            quot_q   <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (op_req_s) begin
                        op_a_q   <= src_a_i;
                        op_b_q   <= src_b_i;
                        signed_q <= start_signed_s;
                        cnt_q    <= 6'd0;
                        rem_q    <= 32'd0;
                        quot_q   <= mag32(src_a_i, div_signed_s);
                        if (div_req_s) begin
`ifdef MULDIV_DIV0_EARLY_OUT_EN
                            if (div0_s) begin
                                hi_q    <= src_a_i;
                                lo_q    <= div0_lo_s;
                                valid_q <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_DIV;
                            end
`else
                            state_q <= ST_DIV;
`endif
                        end else begin
                            state_q <= ST_MUL;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    hi_q    <= product_s[63:32];
                    lo_q    <= product_s[31:0];
                    valid_q <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DIV: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_ITERS - 1)) begin
                        hi_q    <= rem_fix_s;
                        lo_q    <= quot_fix_s;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    if (hold_i) begin
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
